// File: rtl/riscv_core_if.sv
// Bus interface for riscv_core: program (ROM) port and byte-addressed data port.
// master = core side, slave = memory/MMIO side.
interface riscv_core_if;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic [31:0] data_addr;
    logic [31:0] data_rd;
    logic [31:0] data_wr;
    logic [3:0]  data_wr_en;

    modport master (
        output prog_addr,
        input  prog_data,
        output data_addr,
        input  data_rd,
        output data_wr,
        output data_wr_en
    );

    modport slave (
        input  prog_addr,
        output prog_data,
        input  data_addr,
        output data_rd,
        input  data_wr,
        input  data_wr_en
    );
endinterface

// File: rtl/riscv_core.sv
// Single-cycle RV32I core: fetch, decode, execute and retire one instruction per clk.
// Optional feature macro: RISCV_MUL_EN adds MUL (low 32 bits of rs1*rs2).
// Without it every funct7=0000001 R-type instruction decodes as a NOP.
module riscv_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    riscv_core_if.master bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic        rd_we_d;
    logic [31:0] rd_data_d;
    logic [3:0]  wr_en_d;
    logic [31:0] wr_data_d;

    // Instruction fields and immediates
    logic [31:0] instr;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, eff_addr, pc_plus4;
    logic [31:0] ld_byte_word, ld_half_word;

    assign instr  = bus.prog_data;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Both read ports are asynchronous; rf_q[0] is tied to zero so x0 reads 0.
    assign rs1_val  = rf_q[rs1];
    assign rs2_val  = rf_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;
    assign eff_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    // Load lane selection: shift the addressed byte/halfword down to bit 0.
    assign ld_byte_word = bus.data_rd >> {eff_addr[1:0], 3'b000};
    assign ld_half_word = bus.data_rd >> {eff_addr[1], 4'b0000};

    assign bus.prog_addr  = pc_q;
    assign bus.data_addr  = eff_addr;
    assign bus.data_wr    = wr_data_d;
    assign bus.data_wr_en = rst ? 4'b0000 : wr_en_d;

    // Decode/execute: next PC, register write-back and store strobes.
    always_comb begin
        pc_d      = pc_plus4;
        rd_we_d   = 1'b0;
        rd_data_d = 32'h0;
        wr_en_d   = 4'b0000;
        wr_data_d = rs2_val;
        unique case (opcode)
            OP_LUI: begin
                rd_we_d   = 1'b1;
                rd_data_d = imm_u;
            end
            OP_AUIPC: begin
                rd_we_d   = 1'b1;
                rd_data_d = pc_q + imm_u;
            end
            OP_JAL: begin
                rd_we_d   = 1'b1;
                rd_data_d = pc_plus4;
                pc_d      = pc_q + imm_j;
            end
            OP_JALR: begin
                // rs1 is sampled combinationally, so rd==rs1 still uses the old value.
                rd_we_d   = 1'b1;
                rd_data_d = pc_plus4;
                pc_d      = (rs1_val + imm_i) & ~32'h1;
            end
            OP_BRANCH: begin
                logic taken;
                case (funct3)
                    3'b000:  taken = (rs1_val == rs2_val);
                    3'b001:  taken = (rs1_val != rs2_val);
                    3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
                    3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  taken = (rs1_val <  rs2_val);
                    3'b111:  taken = (rs1_val >= rs2_val);
                    default: taken = 1'b0;
                endcase
                if (taken) pc_d = pc_q + imm_b;
            end
            OP_LOAD: begin
                rd_we_d = 1'b1;
                case (funct3)
                    3'b000:  rd_data_d = {{24{ld_byte_word[7]}}, ld_byte_word[7:0]};
                    3'b001:  rd_data_d = {{16{ld_half_word[15]}}, ld_half_word[15:0]};
                    3'b010:  rd_data_d = bus.data_rd;
                    3'b100:  rd_data_d = {24'h0, ld_byte_word[7:0]};
                    3'b101:  rd_data_d = {16'h0, ld_half_word[15:0]};
                    default: rd_we_d   = 1'b0;
                endcase
            end
            OP_STORE: begin
                case (funct3)
                    3'b000: begin
                        wr_en_d   = 4'b0001 << eff_addr[1:0];
                        wr_data_d = {4{rs2_val[7:0]}};
                    end
                    3'b001: begin
                        wr_en_d   = eff_addr[1] ? 4'b1100 : 4'b0011;
                        wr_data_d = {2{rs2_val[15:0]}};
                    end
                    3'b010:  wr_en_d = 4'b1111;
                    default: wr_en_d = 4'b0000;
                endcase
            end
            OP_IMM: begin
                rd_we_d = 1'b1;
                case (funct3)
                    3'b000: rd_data_d = rs1_val + imm_i;
                    3'b010: rd_data_d = {31'h0, $signed(rs1_val) < $signed(imm_i)};
                    3'b011: rd_data_d = {31'h0, rs1_val < imm_i};
                    3'b100: rd_data_d = rs1_val ^ imm_i;
                    3'b110: rd_data_d = rs1_val | imm_i;
                    3'b111: rd_data_d = rs1_val & imm_i;
                    3'b001: rd_data_d = rs1_val << rs2;
                    default: rd_data_d = funct7[5] ? 32'($signed(rs1_val) >>> rs2)
                                                   : (rs1_val >> rs2);
                endcase
            end
            OP_REG: begin
                rd_we_d = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  rd_data_d = rs1_val + rs2_val;
                        3'b001:  rd_data_d = rs1_val << rs2_val[4:0];
                        3'b010:  rd_data_d = {31'h0, $signed(rs1_val) < $signed(rs2_val)};
                        3'b011:  rd_data_d = {31'h0, rs1_val < rs2_val};
                        3'b100:  rd_data_d = rs1_val ^ rs2_val;
                        3'b101:  rd_data_d = rs1_val >> rs2_val[4:0];
                        3'b110:  rd_data_d = rs1_val | rs2_val;
                        default: rd_data_d = rs1_val & rs2_val;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    rd_data_d = rs1_val - rs2_val;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    rd_data_d = 32'($signed(rs1_val) >>> rs2_val[4:0]);
`ifdef RISCV_MUL_EN
                end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
                    rd_data_d = rs1_val * rs2_val;
`endif
                end else begin
                    rd_we_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Program counter: reset vector on rst, otherwise the decoded next PC.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    // Register file: x0 hard-wired to zero, x1..x31 cleared by reset.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_q[gi] = 32'h0;
            end else begin : g_reg
                // One write port: update this register when it is the destination.
                always_ff @(posedge clk) begin
                    if (rst)
                        rf_q[gi] <= 32'h0;
                    else if (rd_we_d && rd == 5'(gi))
                        rf_q[gi] <= rd_data_d;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_riscv_core.sv
// Self-checking bench for riscv_core: the bench plays the ROM/RAM, feeding one
// instruction per cycle and comparing PC and data-port activity against a scoreboard.
module tb_riscv_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    riscv_core_if bus ();

    riscv_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  en;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          chk_addr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Instruction encoders
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm20[19:0], rd, op};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, push its expected effect, then compare once outputs settle.
    task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] drd, input logic [3:0] en,
                        input logic [31:0] addr, input logic [31:0] wd, input bit chk_addr);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.prog_data = instr;
        bus.data_rd   = drd;
        sb_q.push_back('{pc, en, addr, wd, chk_addr});
        #1;
        e = sb_q.pop_front();
        $display("pc=0x%08h instr=0x%08h wr_en=%b addr=0x%08h wr=0x%08h",
                 bus.prog_addr, instr, bus.data_wr_en, bus.data_addr, bus.data_wr);
        check_val($sformatf("pc@%0h", e.pc), bus.prog_addr, e.pc);
        check_val($sformatf("wr_en@%0h", e.pc), {28'h0, bus.data_wr_en}, {28'h0, e.en});
        if (e.en != 4'b0000 || e.chk_addr)
            check_val($sformatf("addr@%0h", e.pc), bus.data_addr, e.addr);
        if (e.en != 4'b0000)
            check_val($sformatf("wdata@%0h", e.pc), bus.data_wr & {{8{e.en[3]}}, {8{e.en[2]}},
                      {8{e.en[1]}}, {8{e.en[0]}}}, e.wd);
    endtask

    logic [31:0] sw_probe;
    logic [31:0] mul_exp;

    initial begin
        sw_probe      = enc_s(32'h100, 5'd0, 5'd0, 3'b010);
        bus.prog_data = sw_probe;
        bus.data_rd   = 32'h0;
`ifdef RISCV_MUL_EN
        mul_exp = 32'd42;
`else
        mul_exp = 32'd9;
`endif
        @(posedge clk);
        // Reset held: PC at vector, store strobes suppressed.
        step(1, 32'h00, sw_probe, 0, 4'h0, 0, 0, 0);
        step(1, 32'h00, sw_probe, 0, 4'h0, 0, 0, 0);
        // Arithmetic and compares
        step(0, 32'h00, enc_i(5, 0, 3'b000, 1, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h04, enc_i(-3, 0, 3'b000, 2, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h08, enc_r(7'h00, 2, 1, 3'b000, 3), 0, 4'h0, 0, 0, 0);
        step(0, 32'h0C, enc_r(7'h00, 1, 2, 3'b010, 4), 0, 4'h0, 0, 0, 0);
        step(0, 32'h10, enc_r(7'h00, 1, 2, 3'b011, 5), 0, 4'h0, 0, 0, 0);
        step(0, 32'h14, enc_s(32'h100, 3, 0, 3'b010), 0, 4'hF, 32'h100, 32'd2, 1);
        step(0, 32'h18, enc_s(32'h104, 4, 0, 3'b010), 0, 4'hF, 32'h104, 32'd1, 1);
        step(0, 32'h1C, enc_s(32'h108, 5, 0, 3'b010), 0, 4'hF, 32'h108, 32'd0, 1);
        // MMIO word store
        step(0, 32'h20, enc_u(32'h20000, 6, 7'b0110111), 0, 4'h0, 0, 0, 0);
        step(0, 32'h24, enc_i(32'hA, 0, 3'b000, 7, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h28, enc_s(0, 7, 6, 3'b010), 0, 4'hF, 32'h2000_0000, 32'h0000_000A, 1);
        // Byte store/load with sign and zero extension
        step(0, 32'h2C, enc_u(32'h10000, 8, 7'b0110111), 0, 4'h0, 0, 0, 0);
        step(0, 32'h30, enc_i(32'h80, 0, 3'b000, 9, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h34, enc_s(3, 9, 8, 3'b000), 0, 4'h8, 32'h1000_0003, 32'h8000_0000, 1);
        step(0, 32'h38, enc_i(3, 8, 3'b000, 10, 7'b0000011), 32'h8012_3456, 4'h0, 32'h1000_0003, 0, 1);
        step(0, 32'h3C, enc_i(3, 8, 3'b100, 11, 7'b0000011), 32'h8012_3456, 4'h0, 32'h1000_0003, 0, 1);
        step(0, 32'h40, enc_s(32'h10C, 10, 0, 3'b010), 0, 4'hF, 32'h10C, 32'hFFFF_FF80, 1);
        step(0, 32'h44, enc_s(32'h110, 11, 0, 3'b010), 0, 4'hF, 32'h110, 32'h0000_0080, 1);
        // Halfword store/load, shifts
        step(0, 32'h48, enc_s(2, 9, 8, 3'b001), 0, 4'hC, 32'h1000_0002, 32'h0080_0000, 1);
        step(0, 32'h4C, enc_i(2, 8, 3'b001, 12, 7'b0000011), 32'h8001_0000, 4'h0, 32'h1000_0002, 0, 1);
        step(0, 32'h50, enc_s(32'h114, 12, 0, 3'b010), 0, 4'hF, 32'h114, 32'hFFFF_8001, 1);
        step(0, 32'h54, enc_i(32'h404, 12, 3'b101, 13, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h58, enc_s(32'h118, 13, 0, 3'b010), 0, 4'hF, 32'h118, 32'hFFFF_F800, 1);
        step(0, 32'h5C, enc_i(28, 12, 3'b101, 14, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h60, enc_s(32'h11C, 14, 0, 3'b010), 0, 4'hF, 32'h11C, 32'h0000_000F, 1);
        // x0 write discarded
        step(0, 32'h64, enc_i(7, 0, 3'b000, 0, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h68, enc_r(7'h00, 0, 0, 3'b000, 1), 0, 4'h0, 0, 0, 0);
        step(0, 32'h6C, enc_s(32'h120, 1, 0, 3'b010), 0, 4'hF, 32'h120, 32'd0, 1);
        // MUL (or NOP when the multiplier is not built)
        step(0, 32'h70, enc_i(7, 0, 3'b000, 1, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h74, enc_i(6, 0, 3'b000, 2, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h78, enc_i(9, 0, 3'b000, 3, OP_IMM), 0, 4'h0, 0, 0, 0);
        step(0, 32'h7C, enc_r(7'h01, 2, 1, 3'b000, 3), 0, 4'h0, 0, 0, 0);
        step(0, 32'h80, enc_s(32'h124, 3, 0, 3'b010), 0, 4'hF, 32'h124, mul_exp, 1);
        // Control flow
        step(0, 32'h84, enc_b(8, 0, 0, 3'b000), 0, 4'h0, 0, 0, 0);
        step(0, 32'h8C, enc_b(8, 0, 0, 3'b001), 0, 4'h0, 0, 0, 0);
        step(0, 32'h90, enc_b(32'h10, 1, 2, 3'b100), 0, 4'h0, 0, 0, 0);
        step(0, 32'hA0, enc_j(-16, 15), 0, 4'h0, 0, 0, 0);
        step(0, 32'h90, enc_b(8, 1, 2, 3'b111), 0, 4'h0, 0, 0, 0);
        step(0, 32'h94, enc_i(1, 15, 3'b000, 0, 7'b1100111), 0, 4'h0, 0, 0, 0);
        step(0, 32'hA4, enc_s(32'h128, 15, 0, 3'b010), 0, 4'hF, 32'h128, 32'h0000_00A4, 1);
        // ECALL is a NOP, then AUIPC
        step(0, 32'hA8, 32'h0000_0073, 0, 4'h0, 0, 0, 0);
        step(0, 32'hAC, enc_u(32'h1, 16, 7'b0010111), 0, 4'h0, 0, 0, 0);
        step(0, 32'hB0, enc_s(32'h12C, 16, 0, 3'b010), 0, 4'hF, 32'h12C, 32'h0000_10AC, 1);
        // Reset mid-program: store suppressed, PC and registers return to reset state
        step(1, 32'hB4, enc_s(32'h12C, 16, 0, 3'b010), 0, 4'h0, 0, 0, 0);
        step(0, 32'h00, enc_s(32'h12C, 16, 0, 3'b010), 0, 4'hF, 32'h12C, 32'h0, 1);
        step(0, 32'h04, 32'h0000_0013, 0, 4'h0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
